// File: rtl/axi_rd_arbiter.sv
// Shares one single-beat AXI4 read channel between instruction fetch and data loads.
// Loads win arbitration until STARVE_MAX consecutive load grants have passed a waiting fetch.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned ID_INST    = 0,
  parameter int unsigned ID_DATA    = 1,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_flush,
  output logic              inst_ack,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [2:0]        data_size,
  output logic              data_ack,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              rerr,
  output logic              busy,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic [7:0]        arlen,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  state_t           state;
  owner_t           owner;
  logic             drop;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_data;
  logic             grant_inst;
  logic             kill;
  logic             unused_rid;

  assign grant_data = data_req && ((starve_cnt < CNT_W'(STARVE_MAX)) || !inst_req);
  assign grant_inst = !grant_data && inst_req && !inst_flush;
  // A flush arriving with the final beat also kills that beat.
  assign kill       = drop || inst_flush;

  assign inst_ack   = (state == AR) && arready && (owner == OWN_INST);
  assign data_ack   = (state == AR) && arready && (owner == OWN_DATA);
  assign busy       = (state != IDLE);
  assign arlen      = 8'd0;
  assign arburst    = 2'b01;
  assign unused_rid = ^rid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_INST;
      drop        <= 1'b0;
      starve_cnt  <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      arid        <= '0;
      araddr      <= '0;
      arsize      <= 3'd0;
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      rerr        <= 1'b0;
      inst_rdata  <= '0;
      data_rdata  <= '0;
    end else begin
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      rerr        <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            owner   <= OWN_DATA;
            arid    <= ID_W'(ID_DATA);
            araddr  <= data_addr;
            arsize  <= data_size;
            arvalid <= 1'b1;
            state   <= AR;
            if (!inst_req)
              starve_cnt <= '0;
            else if (starve_cnt < CNT_W'(STARVE_MAX))
              starve_cnt <= starve_cnt + CNT_W'(1);
          end else if (grant_inst) begin
            owner      <= OWN_INST;
            arid       <= ID_W'(ID_INST);
            araddr     <= inst_addr;
            arsize     <= 3'b010;
            arvalid    <= 1'b1;
            state      <= AR;
            starve_cnt <= '0;
          end else if (!inst_req) begin
            starve_cnt <= '0;
          end
        end
        AR: begin
          if (inst_flush && (owner == OWN_INST))
            drop <= 1'b1;
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (inst_flush && (owner == OWN_INST))
            drop <= 1'b1;
          if (rvalid && rlast) begin
            rready <= 1'b0;
            drop   <= 1'b0;
            state  <= IDLE;
            if (owner == OWN_DATA) begin
              data_rvalid <= 1'b1;
              data_rdata  <= rdata;
              rerr        <= (rresp != 2'b00);
            end else if (!kill) begin
              inst_rvalid <= 1'b1;
              inst_rdata  <= rdata;
              rerr        <= (rresp != 2'b00);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Shares one AXI4 read channel (AR/R) between two requesters: the instruction-fetch side, whose response feeds the IF/ID register as its valid/pc/inst source, and the data-load side from MEM. Only one read is outstanding at a time, and each read is a single beat. Data requests have priority, with an anti-starvation rule for fetch. A pending fetch response can be killed by a pipeline flush, so no stale instruction reaches ID.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
ID_W, 4, AXI ID width
ID_INST, 0, arid used for fetch reads
ID_DATA, 1, arid used for data reads
STARVE_MAX, 2, consecutive data grants allowed while inst_req is pending

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; asynchronous, active-high
inst_req  in  1  fetch request; held with inst_addr until inst_ack
inst_addr  in  ADDR_W  fetch address
inst_flush  in  1  pipeline flush; kill pending or in-flight fetch response
inst_ack  out  1  fetch AR handshake done (combinational pulse)
inst_rvalid  out  1  one-cycle pulse, fetch data valid (registered)
inst_rdata  out  DATA_W  fetch data, valid with inst_rvalid
data_req  in  1  load request; held with addr/size until data_ack
data_addr  in  ADDR_W  load address
data_size  in  3  AXI arsize for load
data_ack  out  1  load AR handshake done (combinational pulse)
data_rvalid  out  1  one-cycle pulse, load data valid (registered)
data_rdata  out  DATA_W  load data
rerr  out  1  pulses with inst_rvalid/data_rvalid when rresp != OKAY
busy  out  1  state != IDLE
arid/araddr/arsize  out  ID_W/ADDR_W/3  AR payload
arlen  out  8  constant 0
arburst  out  2  constant 2'b01
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  ID_W  ignored; one read outstanding
rdata  in  DATA_W  read data
rresp  in  2  read response
rlast  in  1  last beat
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Reset (async, immediate):
  - state=IDLE; arvalid=0, rready=0.
  - inst_rvalid=0, data_rvalid=0, rerr=0; inst_rdata=0, data_rdata=0.
  - arid/araddr/arsize=0; owner=INST; drop=0; starve_cnt=0.
- FSM states: IDLE, AR, R.
- IDLE, grant rule:
  - If data_req and (starve_cnt < STARVE_MAX or !inst_req), grant DATA.
  - Else if inst_req and !inst_flush, grant INST.
  - On grant: latch owner and AR payload (INST uses arsize=3'b010); set arvalid=1; go to AR.
- AR:
  - Hold arvalid and payload stable until arready.
  - On arready: pulse the owner's ack in the same cycle; set arvalid=0, rready=1; go to R.
- R:
  - On rvalid && rlast: register rdata into the owner's rdata and pulse the owner's rvalid next cycle; rerr=(rresp!=0) with it; set rready=0; go to IDLE.
  - rvalid without rlast is not expected (arlen=0); the beat is consumed, state unchanged.
- Flush:
  - inst_flush while owner=INST in AR or R sets drop=1. The AR is not retracted; it completes, and the R beat is consumed silently (no inst_rvalid, no rerr).
  - drop clears on return to IDLE.
  - Flush has no effect on DATA transactions.
- Starvation:
  - starve_cnt increments on each DATA grant while inst_req=1.
  - It clears on an INST grant or when inst_req=0 in IDLE.
  - It saturates at STARVE_MAX.
- Timing:
  - Minimum latency: req sampled at edge N; arvalid at N+1; with arready=1 and rvalid next cycle, owner rvalid at N+3; IDLE re-arbitrates at N+3, so the next arvalid is at N+4.
- Simultaneous events:
  - inst_flush in the same IDLE cycle as inst_req means no INST grant.
  - data_req and inst_req together follow the grant rule.
  - Requests arriving while busy wait; there is no queueing beyond the held req.
- Reset mid-transaction aborts immediately; the AXI slave shares rst.

Test Plan:
1. Single fetch: inst_req=1, addr=0xBFC00000, arready=1, rdata=0x3C080001 next cycle → arid=0, arsize=2, arlen=0; inst_ack pulse; inst_rvalid pulse with inst_rdata=0x3C080001; data_rvalid stays 0.
2. Same-cycle requests: inst_req and data_req (addr 0x80001000, size 2) → DATA granted first (arid=1), then INST; two transactions, ordered, no overlap of arvalid.
3. Starvation: data_req held high with inst_req high → grants DATA, DATA, INST, DATA, DATA, INST (STARVE_MAX=2).
4. Flush in R: INST in R, pulse inst_flush, then rvalid/rlast → beat consumed, inst_rvalid never pulses; the next inst_req is served normally.
5. Error and backpressure: arready held low 5 cycles, then rresp=2'b10 → arvalid and payload stable for 5 cycles; owner rvalid pulses with rerr=1.
6. Async reset in AR: assert rst mid-cycle → arvalid, rready and busy drop before the next edge; after release, state=IDLE and a fresh request completes.
